// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB requester.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;

    // Wide enough for the largest legal TIMEOUT (255)
    localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on PREADY and flags the last allowed one.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    // Clear wins over count so a fresh ACCESS phase always starts from zero
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The k-th ACCESS cycle sees a count of k-1, so this marks the TIMEOUT-th one
    assign tc = (cnt_q == WAIT_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one APB transfer with a
// one-cycle completion pulse, aborting if the completer stalls too long.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
);

    apb_state_t        state_q, state_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic accept;
    logic timer_clear;
    logic timer_en;
    logic timer_tc;

    apb_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk    (PCLK),
        .rst    (PRESET),
        .clear  (timer_clear),
        .enable (timer_en),
        .tc     (timer_tc)
    );

    // Ready in IDLE, or in ACCESS on the completing cycle (a timeout is not a completion)
    assign cmd_ready = !PRESET &&
                       ((state_q == IDLE) || ((state_q == ACCESS) && PREADY));
    assign accept    = cmd_valid && cmd_ready;

    // Next-state, command capture and response generation
    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;

        if (accept) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                timer_clear = 1'b1;
                state_d     = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    state_d     = accept ? SETUP : IDLE;
                end else if (timer_tc) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, APB request and response registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign PSELx     = (state_q != IDLE);
    assign PENABLE   = (state_q == ACCESS);
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed table, back-to-back,
// randomized command streams and a mid-transfer reset.
module tb_apb_master;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TO   = 16;
    localparam int MAXC = 2048;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSELx;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PREADY;
    logic [DW-1:0] PRDATA;

    always #5 PCLK = ~PCLK;

    apb_master #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d] got=0x%0h want=0x%0h", name, idx, act, exp);
        end
    endtask

    // One command: waits = ACCESS cycles with PREADY low before it rises
    // (>= TO means it never rises). b2b presents the next command from the
    // SETUP cycle onward; otherwise the next one follows after gap idle cycles.
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] prdata;
        bit            b2b;
        int            gap;
    } cmd_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] prdata;
        int            exp_lat;
        logic          exp_err;
        logic [DW-1:0] exp_rd;
    } vec_t;

    cmd_t cq[32];

    // Per-cycle drive and expectation timeline
    logic          d_v[MAXC], d_wr[MAXC], d_rdy[MAXC];
    logic [AW-1:0] d_addr[MAXC];
    logic [DW-1:0] d_wd[MAXC], d_prd[MAXC];
    logic          e_sel[MAXC], e_en[MAXC], e_rdy[MAXC], e_rv[MAXC], e_err[MAXC], e_wr[MAXC];
    logic [AW-1:0] e_addr[MAXC];
    logic [DW-1:0] e_rd[MAXC], e_wd[MAXC];

    // Last accepted command, which the APB request outputs must hold
    logic          h_wr;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wd;

    int obs_lat, rsp_cnt;
    logic          obs_err;
    logic [DW-1:0] obs_rd;

    // Build the expected timeline from the protocol rules, then drive it
    // cycle by cycle. Called at a falling edge; returns at a falling edge.
    task automatic run_seq(input int ncmd);
        int a, p, n, r, last;
        bit to;
        for (int c = 0; c < MAXC; c++) begin
            d_v[c]   = 1'b0;
            d_wr[c]  = 1'($urandom);
            d_addr[c] = $urandom;
            d_wd[c]  = $urandom;
            d_rdy[c] = 1'($urandom);
            d_prd[c] = $urandom;
            e_sel[c] = 1'b0;
            e_en[c]  = 1'b0;
            e_rdy[c] = 1'b1;
            e_rv[c]  = 1'b0;
            e_err[c] = 1'b0;
            e_rd[c]  = '0;
            e_addr[c] = h_addr;
            e_wr[c]  = h_wr;
            e_wd[c]  = h_wd;
        end
        a = 0;
        p = 0;
        last = 0;
        for (int i = 0; i < ncmd; i++) begin
            for (int c = p; c <= a; c++) begin
                d_v[c]    = 1'b1;
                d_wr[c]   = cq[i].wr;
                d_addr[c] = cq[i].addr;
                d_wd[c]   = cq[i].wdata;
            end
            to = (cq[i].waits >= TO);
            n  = to ? TO : cq[i].waits + 1;
            e_sel[a+1] = 1'b1;
            e_en[a+1]  = 1'b0;
            e_rdy[a+1] = 1'b0;
            for (int k = 1; k <= n; k++) begin
                e_sel[a+1+k] = 1'b1;
                e_en[a+1+k]  = 1'b1;
                d_rdy[a+1+k] = (k == n) && !to;
                e_rdy[a+1+k] = (k == n) && !to;
            end
            d_prd[a+1+n] = cq[i].prdata;
            r = a + 2 + n;
            e_rv[r]  = 1'b1;
            e_err[r] = to;
            e_rd[r]  = (!to && !cq[i].wr) ? cq[i].prdata : '0;
            for (int c = a + 1; c < MAXC; c++) begin
                e_addr[c] = cq[i].addr;
                e_wr[c]   = cq[i].wr;
                e_wd[c]   = cq[i].wdata;
            end
            h_addr = cq[i].addr;
            h_wr   = cq[i].wr;
            h_wd   = cq[i].wdata;
            if (cq[i].b2b) begin
                p = a + 1;
                a = to ? r : a + 1 + n;
            end else begin
                a = r + cq[i].gap;
                p = a;
            end
            last = r + 1;
        end
        obs_lat = -1;
        obs_err = 1'b0;
        obs_rd  = '0;
        rsp_cnt = 0;
        for (int c = 0; c <= last; c++) begin
            cmd_valid = d_v[c];
            cmd_write = d_wr[c];
            cmd_addr  = d_addr[c];
            cmd_wdata = d_wd[c];
            PREADY    = d_rdy[c];
            PRDATA    = d_prd[c];
            #1;
            chk("cmd_ready", c, 64'(cmd_ready), 64'(e_rdy[c]));
            chk("PSELx",     c, 64'(PSELx),     64'(e_sel[c]));
            chk("PENABLE",   c, 64'(PENABLE),   64'(e_en[c]));
            chk("rsp_valid", c, 64'(rsp_valid), 64'(e_rv[c]));
            chk("PADDR",     c, 64'(PADDR),     64'(e_addr[c]));
            chk("PWRITE",    c, 64'(PWRITE),    64'(e_wr[c]));
            chk("PWDATA",    c, 64'(PWDATA),    64'(e_wd[c]));
            if (e_rv[c]) begin
                chk("rsp_err",   c, 64'(rsp_err),   64'(e_err[c]));
                chk("rsp_rdata", c, 64'(rsp_rdata), 64'(e_rd[c]));
            end
            if (rsp_valid) begin
                rsp_cnt++;
                if (obs_lat < 0) begin
                    obs_lat = c;
                    obs_err = rsp_err;
                    obs_rd  = rsp_rdata;
                end
            end
            @(negedge PCLK);
        end
        cmd_valid = 1'b0;
    endtask

    vec_t vt[6];

    initial begin
        // Hand-written single-command vectors with expected response cycle
        // (counted from the accept cycle), error flag and read data.
        vt[0] = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 0,  32'h0BAD0BAD, 3,  1'b0, 32'h0};
        vt[1] = '{1'b0, 32'h0000_0020, 32'h0,        3,  32'h12345678, 6,  1'b0, 32'h12345678};
        vt[2] = '{1'b0, 32'h0000_0030, 32'h0,        16, 32'hCAFEF00D, 18, 1'b1, 32'h0};
        vt[3] = '{1'b0, 32'h0000_0040, 32'h0,        15, 32'hA5A5A5A5, 18, 1'b0, 32'hA5A5A5A5};
        vt[4] = '{1'b1, 32'h0000_0044, 32'h00000011, 16, 32'h00000005, 18, 1'b1, 32'h0};
        vt[5] = '{1'b0, 32'h0000_0050, 32'h0,        0,  32'hFFFF0000, 3,  1'b0, 32'hFFFF0000};

        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PREADY    = 1'b0;
        PRDATA    = '0;

        // Reset state
        repeat (3) @(negedge PCLK);
        #1;
        chk("rst_cmd_ready", 0, 64'(cmd_ready), 64'(0));
        chk("rst_PSELx",     0, 64'(PSELx),     64'(0));
        chk("rst_PENABLE",   0, 64'(PENABLE),   64'(0));
        chk("rst_PADDR",     0, 64'(PADDR),     64'(0));
        chk("rst_rsp_valid", 0, 64'(rsp_valid), 64'(0));
        @(negedge PCLK);
        PRESET = 1'b0;
        h_wr   = 1'b0;
        h_addr = '0;
        h_wd   = '0;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            cq[0] = '{vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].waits, vt[i].prdata, 1'b0, 0};
            run_seq(1);
            chk("tbl_latency", i, 64'(obs_lat),  64'(vt[i].exp_lat));
            chk("tbl_err",     i, 64'(obs_err),  64'(vt[i].exp_err));
            chk("tbl_rdata",   i, 64'(obs_rd),   64'(vt[i].exp_rd));
            chk("tbl_rsp_cnt", i, 64'(rsp_cnt),  64'(1));
        end

        // Back-to-back write 0x4 then read 0x8
        cq[0] = '{1'b1, 32'h4, 32'h0000_AAAA, 0, 32'h0,        1'b1, 0};
        cq[1] = '{1'b0, 32'h8, 32'h0,         0, 32'h8888_7777, 1'b0, 0};
        run_seq(2);
        chk("b2b_rsp_cnt", 0, 64'(rsp_cnt), 64'(2));

        // Timeout with the next command already waiting: it must not be taken
        // on the aborting cycle
        cq[0] = '{1'b0, 32'h70, 32'h0,  TO, 32'h1, 1'b1, 0};
        cq[1] = '{1'b1, 32'h74, 32'h99, 1,  32'h2, 1'b0, 0};
        run_seq(2);
        chk("to_b2b_rsp_cnt", 0, 64'(rsp_cnt), 64'(2));

        // Randomized command streams
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int i = 0; i < 24; i++) begin
                cq[i].wr     = 1'($urandom);
                cq[i].addr   = $urandom;
                cq[i].wdata  = $urandom;
                cq[i].prdata = $urandom;
                case ($urandom_range(0, 9))
                    0:       cq[i].waits = TO + int'($urandom_range(0, 1));
                    1:       cq[i].waits = TO - 1;
                    default: cq[i].waits = int'($urandom_range(0, 4));
                endcase
                cq[i].b2b = 1'($urandom);
                cq[i].gap = int'($urandom_range(0, 2));
            end
            run_seq(24);
            chk("rnd_rsp_cnt", rnd, 64'(rsp_cnt), 64'(24));
        end

        // Reset asserted while in ACCESS
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0060;
        cmd_wdata = 32'hFFFF_FFFF;
        PREADY    = 1'b0;
        #1;
        chk("mr_accept", 0, 64'(cmd_ready), 64'(1));
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        #1;
        chk("mr_in_access", 0, 64'(PENABLE), 64'(1));
        PRESET    = 1'b1;
        PREADY    = 1'b1;
        cmd_valid = 1'b1;
        #1;
        chk("mr_ready_in_rst", 0, 64'(cmd_ready), 64'(0));
        @(negedge PCLK);
        #1;
        chk("mr_PSELx",     1, 64'(PSELx),     64'(0));
        chk("mr_PENABLE",   1, 64'(PENABLE),   64'(0));
        chk("mr_PWRITE",    1, 64'(PWRITE),    64'(0));
        chk("mr_PADDR",     1, 64'(PADDR),     64'(0));
        chk("mr_PWDATA",    1, 64'(PWDATA),    64'(0));
        chk("mr_rsp_valid", 1, 64'(rsp_valid), 64'(0));
        chk("mr_rsp_err",   1, 64'(rsp_err),   64'(0));
        chk("mr_rsp_rdata", 1, 64'(rsp_rdata), 64'(0));
        chk("mr_cmd_ready", 1, 64'(cmd_ready), 64'(0));
        @(negedge PCLK);
        #1;
        chk("mr_rsp_valid", 2, 64'(rsp_valid), 64'(0));
        @(negedge PCLK);
        PRESET = 1'b0;
        h_wr   = 1'b0;
        h_addr = '0;
        h_wd   = '0;
        cq[0] = '{1'b0, 32'h0000_0064, 32'h0, 1, 32'h5555_AAAA, 1'b0, 0};
        run_seq(1);
        chk("mr_after_lat", 0, 64'(obs_lat), 64'(4));
        chk("mr_after_rd",  0, 64'(obs_rd),  64'(32'h5555_AAAA));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound on the whole run
    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
